sc_read_scheduler: RTL and testbench

//  Shares the single register-file read path (38-to-1 read decoder, 6-bit selection) among
//  NUM_REQ requesters (control unit, debug port, ...). Round-robin arbitration, request/valid

---
 rtl/sc_read_scheduler_pkg.sv | 17 +
 rtl/sc_rr_arbiter.sv | 35 +++
 rtl/sc_read_scheduler.sv | 121 ++++++++++++
 tb/tb_sc_read_scheduler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sc_read_scheduler_pkg.sv
// Shared types and helpers for the register-file read scheduler.
// Holds the FSM state encoding, the default register count and the index range check.
package sc_read_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SELECT  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  localparam int unsigned NUM_REGS_DEFAULT = 38;

  function automatic logic idx_in_range(input int unsigned idx, input int unsigned num_regs);
    return idx < num_regs;
  endfunction

endpackage

// File: rtl/sc_rr_arbiter.sv
// Combinational round-robin pick: first unmasked request at or after the pointer,
// wrapping from NUM_REQ-1 back to 0.
module sc_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTRW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_mask,
  input  logic [PTRW-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_valid
);

  logic [NUM_REQ-1:0] w_eff;
  logic               w_found;
  int unsigned        w_idx;

  assign w_eff = i_req & ~i_mask;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = (32'(i_ptr) + k) % NUM_REQ;
      if (!w_found && w_eff[PTRW'(w_idx)]) begin
        o_grant[PTRW'(w_idx)] = 1'b1;
        w_found               = 1'b1;
      end
    end
  end

  assign o_valid = w_found;

endmodule

// File: rtl/sc_read_scheduler.sv
// Time-shares the register-file read decoder among NUM_REQ requesters with
// round-robin arbitration; one read per two cycles, registered data and pulses.
module sc_read_scheduler
  import sc_read_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ                 = 4,
  parameter int unsigned DATAWIDTH_MUX_SELECTION = 6,
  parameter int unsigned DATAWIDTH_BUS           = 32,
  parameter int unsigned NUM_REGS                = NUM_REGS_DEFAULT
) (
  input  logic                                       SC_READ_SCHEDULER_CLOCK_50,
  input  logic                                       SC_READ_SCHEDULER_RESET_InHigh,
  input  logic [NUM_REQ-1:0]                         SC_READ_SCHEDULER_Req_In,
  input  logic [NUM_REQ*DATAWIDTH_MUX_SELECTION-1:0] SC_READ_SCHEDULER_Addr_In,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]         SC_READ_SCHEDULER_Selection_Out,
  input  logic [DATAWIDTH_BUS-1:0]                   SC_READ_SCHEDULER_DataBUS_In,
  output logic [DATAWIDTH_BUS-1:0]                   SC_READ_SCHEDULER_DataBUS_Out,
  output logic [NUM_REQ-1:0]                         SC_READ_SCHEDULER_Grant_Out,
  output logic [NUM_REQ-1:0]                         SC_READ_SCHEDULER_Valid_Out,
  output logic                                       SC_READ_SCHEDULER_Error_Out,
  output logic                                       SC_READ_SCHEDULER_Busy_Out
);

  localparam int unsigned SEL  = DATAWIDTH_MUX_SELECTION;
  localparam int unsigned BUS  = DATAWIDTH_BUS;
  localparam int unsigned PTRW = $clog2(NUM_REQ);

  state_t              r_state, w_state_nxt;
  logic [PTRW-1:0]     r_ptr, r_owner_idx, w_ptr_inc, w_arb_ptr, w_win_idx;
  logic [NUM_REQ-1:0]  r_grant, r_valid, w_arb_mask, w_arb_grant;
  logic                w_arb_valid, w_take, w_win_oor;
  logic [SEL-1:0]      r_sel, w_win_addr;
  logic [BUS-1:0]      r_data;
  logic                r_oor, r_err, r_busy;

  assign w_ptr_inc  = (r_owner_idx == PTRW'(NUM_REQ - 1)) ? '0 : r_owner_idx + PTRW'(1);
  // While completing a read, the pointer already moves past the owner and the owner is masked.
  assign w_arb_ptr  = (r_state == ST_CAPTURE) ? w_ptr_inc : r_ptr;
  assign w_arb_mask = (r_state == ST_CAPTURE) ? r_grant : '0;

  sc_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTRW    (PTRW)
  ) u_arb (
    .i_req   (SC_READ_SCHEDULER_Req_In),
    .i_mask  (w_arb_mask),
    .i_ptr   (w_arb_ptr),
    .o_grant (w_arb_grant),
    .o_valid (w_arb_valid)
  );

  always_ff @(posedge SC_READ_SCHEDULER_CLOCK_50) begin
    if (SC_READ_SCHEDULER_RESET_InHigh) r_state <= ST_IDLE;
    else                                r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_arb_valid) w_state_nxt = ST_SELECT;
      ST_SELECT:  w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: w_state_nxt = w_arb_valid ? ST_SELECT : ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Winner decode: index, its address and whether that address is out of range.
  always_comb begin
    w_take     = w_arb_valid && ((r_state == ST_IDLE) || (r_state == ST_CAPTURE));
    w_win_idx  = '0;
    w_win_addr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_arb_grant[i]) begin
        w_win_idx  = PTRW'(i);
        w_win_addr = SC_READ_SCHEDULER_Addr_In[i*SEL +: SEL];
      end
    end
    w_win_oor = !idx_in_range(32'(w_win_addr), NUM_REGS);
  end

  always_ff @(posedge SC_READ_SCHEDULER_CLOCK_50) begin
    if (SC_READ_SCHEDULER_RESET_InHigh) begin
      r_ptr       <= '0;
      r_owner_idx <= '0;
      r_grant     <= '0;
      r_valid     <= '0;
      r_sel       <= '0;
      r_data      <= '0;
      r_oor       <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_valid <= '0;
      r_err   <= 1'b0;
      if (r_state == ST_SELECT) begin
        r_data  <= r_oor ? '0 : SC_READ_SCHEDULER_DataBUS_In;
        r_valid <= r_grant;
        r_err   <= r_oor;
      end
      if (r_state == ST_CAPTURE) r_ptr <= w_ptr_inc;
      if (w_take) begin
        r_owner_idx <= w_win_idx;
        r_grant     <= w_arb_grant;
        r_sel       <= w_win_oor ? '0 : w_win_addr;
        r_oor       <= w_win_oor;
        r_busy      <= 1'b1;
      end else if (r_state == ST_CAPTURE) begin
        r_grant <= '0;
        r_busy  <= 1'b0;
      end
    end
  end

  assign SC_READ_SCHEDULER_Selection_Out = r_sel;
  assign SC_READ_SCHEDULER_DataBUS_Out   = r_data;
  assign SC_READ_SCHEDULER_Grant_Out     = r_grant;
  assign SC_READ_SCHEDULER_Valid_Out     = r_valid;
  assign SC_READ_SCHEDULER_Error_Out     = r_err;
  assign SC_READ_SCHEDULER_Busy_Out      = r_busy;

endmodule

// File: tb/tb_sc_read_scheduler.sv
// Directed bench for sc_read_scheduler with a decoder model and an expected-read queue.
module tb_sc_read_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [5:0]  addr [4];
  logic [23:0] addr_in;
  logic [5:0]  sel_out;
  logic [31:0] dec_data, data_out;
  logic [3:0]  grant_out, valid_out;
  logic        err_out, busy_out;

  typedef struct {
    logic [3:0]  who;
    logic [5:0]  sel;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   waited;

  always #5 clk = ~clk;

  function automatic logic [31:0] dec_model(input logic [5:0] s);
    if (s == 6'd5) return 32'hDEAD_BEEF;
    return 32'h1000_0000 + 32'(s) * 32'h0101_0101;
  endfunction

  function automatic exp_t mk(input int r, input logic [5:0] a);
    exp_t e;
    e.who  = 4'(1 << r);
    e.err  = (a >= 6'd38);
    e.sel  = e.err ? 6'd0 : a;
    e.data = e.err ? 32'd0 : dec_model(a);
    return e;
  endfunction

  assign addr_in  = {addr[3], addr[2], addr[1], addr[0]};
  assign dec_data = dec_model(sel_out);

  sc_read_scheduler dut (
    .SC_READ_SCHEDULER_CLOCK_50      (clk),
    .SC_READ_SCHEDULER_RESET_InHigh  (rst),
    .SC_READ_SCHEDULER_Req_In        (req),
    .SC_READ_SCHEDULER_Addr_In       (addr_in),
    .SC_READ_SCHEDULER_Selection_Out (sel_out),
    .SC_READ_SCHEDULER_DataBUS_In    (dec_data),
    .SC_READ_SCHEDULER_DataBUS_Out   (data_out),
    .SC_READ_SCHEDULER_Grant_Out     (grant_out),
    .SC_READ_SCHEDULER_Valid_Out     (valid_out),
    .SC_READ_SCHEDULER_Error_Out     (err_out),
    .SC_READ_SCHEDULER_Busy_Out      (busy_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // All outputs at their reset/idle-zero values.
  task automatic chk_zero(input string tag);
    chk({tag, "_sel"},   32'(sel_out),   32'd0);
    chk({tag, "_data"},  data_out,       32'd0);
    chk({tag, "_grant"}, 32'(grant_out), 32'd0);
    chk({tag, "_valid"}, 32'(valid_out), 32'd0);
    chk({tag, "_err"},   32'(err_out),   32'd0);
    chk({tag, "_busy"},  32'(busy_out),  32'd0);
  endtask

  // Advance to the next Valid pulse; n=0 means none within the budget.
  task automatic wait_valid(input int budget, output int n);
    bit seen = 1'b0;
    n = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (valid_out != 4'd0) seen = 1'b1;
    end
    if (!seen) n = 0;
  endtask

  task automatic check_txn(input string tag, input int n);
    exp_t e;
    e = sb.pop_front();
    if (n == 0) begin
      chk({tag, "_timeout"}, 32'(valid_out), 32'(e.who));
    end else begin
      chk({tag, "_valid"}, 32'(valid_out), 32'(e.who));
      chk({tag, "_grant"}, 32'(grant_out), 32'(e.who));
      chk({tag, "_sel"},   32'(sel_out),   32'(e.sel));
      chk({tag, "_data"},  data_out,       e.data);
      chk({tag, "_err"},   32'(err_out),   32'(e.err));
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b1111;
    addr[0] = 6'd1; addr[1] = 6'd2; addr[2] = 6'd3; addr[3] = 6'd4;

    // 1: reset held two cycles with all requests pending
    @(negedge clk); chk_zero("rst_c1");
    @(negedge clk); chk_zero("rst_c2");
    rst = 1'b0;
    @(negedge clk);
    chk("rst_first_grant", 32'(grant_out), 32'h1);
    chk("rst_first_sel",   32'(sel_out),   32'd1);
    chk("rst_first_valid", 32'(valid_out), 32'd0);
    req = 4'b0000;
    sb.push_back(mk(0, 6'd1));
    wait_valid(4, waited); check_txn("rst_read", waited);
    @(negedge clk);
    chk("idle_busy",  32'(busy_out),  32'd0);
    chk("idle_grant", 32'(grant_out), 32'd0);
    chk("idle_sel_hold",  32'(sel_out), 32'd1);
    chk("idle_data_hold", data_out,     dec_model(6'd1));

    // 2: single read, latency t+1 selection, t+2 valid
    req = 4'b0010; addr[1] = 6'd5;
    sb.push_back(mk(1, 6'd5));
    @(negedge clk);
    chk("single_sel",   32'(sel_out),   32'd5);
    chk("single_grant", 32'(grant_out), 32'h2);
    chk("single_busy",  32'(busy_out),  32'd1);
    req = 4'b0000; addr[1] = 6'd9;
    wait_valid(4, waited);
    chk("single_latency", 32'(waited), 32'd1);
    check_txn("single", waited);

    // 3: contention from pointer 0, index 37 is the last valid register
    rst = 1'b1;
    addr[0] = 6'd7; addr[1] = 6'd8; addr[2] = 6'd9; addr[3] = 6'd37;
    req = 4'b1111;
    @(negedge clk); rst = 1'b0;
    sb.push_back(mk(0, 6'd7)); sb.push_back(mk(1, 6'd8));
    sb.push_back(mk(2, 6'd9)); sb.push_back(mk(3, 6'd37));
    sb.push_back(mk(0, 6'd7));
    wait_valid(6, waited); check_txn("rr0", waited);
    for (int i = 1; i < 5; i++) begin
      wait_valid(6, waited);
      chk($sformatf("rr%0d_spacing", i), 32'(waited), 32'd2);
      check_txn($sformatf("rr%0d", i), waited);
    end
    req = 4'b0000;

    // 4: serve req 2 alone, then 0 and 2 together -> 0 first via wrap
    @(negedge clk);
    req = 4'b0100; addr[2] = 6'd11;
    sb.push_back(mk(2, 6'd11));
    wait_valid(6, waited); check_txn("fair_solo2", waited);
    req = 4'b0101; addr[0] = 6'd12; addr[2] = 6'd13;
    sb.push_back(mk(0, 6'd12)); sb.push_back(mk(2, 6'd13));
    wait_valid(6, waited); check_txn("fair_first0", waited);
    req = 4'b0100;
    wait_valid(6, waited); check_txn("fair_then2", waited);
    req = 4'b0000;

    // 5: out-of-range indices 40 and 38
    @(negedge clk);
    req = 4'b0001; addr[0] = 6'd40;
    sb.push_back(mk(0, 6'd40));
    @(negedge clk);
    chk("oor_sel_select", 32'(sel_out), 32'd0);
    req = 4'b0000;
    wait_valid(4, waited); check_txn("oor40", waited);
    @(negedge clk);
    chk("oor_err_pulse",   32'(err_out),   32'd0);
    chk("oor_valid_pulse", 32'(valid_out), 32'd0);
    req = 4'b0100; addr[2] = 6'd38;
    sb.push_back(mk(2, 6'd38));
    wait_valid(6, waited); check_txn("oor38", waited);
    req = 4'b0000;

    // 6: reset while SELECT drives the selection; pointer returns to 0
    @(negedge clk);
    req = 4'b0010; addr[1] = 6'd12; addr[3] = 6'd20;
    @(negedge clk);
    chk("abort_sel",   32'(sel_out),   32'd12);
    chk("abort_grant", 32'(grant_out), 32'h2);
    rst = 1'b1; req = 4'b1010;
    @(negedge clk);
    chk_zero("abort_rst");
    rst = 1'b0;
    sb.push_back(mk(1, 6'd12)); sb.push_back(mk(3, 6'd20));
    @(negedge clk);
    chk("reserve_grant", 32'(grant_out), 32'h2);
    wait_valid(4, waited); check_txn("reserve1", waited);
    req = 4'b1000;
    wait_valid(6, waited);
    chk("reserve3_spacing", 32'(waited), 32'd2);
    check_txn("reserve3", waited);
    req = 4'b0000;
    repeat (3) @(negedge clk);
    chk("end_busy", 32'(busy_out), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
